// File: rtl/inst_issue_arbiter.sv
// Two-requester issue arbiter for the 8-bit pipeline instruction port: per-source FIFOs,
// round-robin selection with a burst limit, a registered output slot and a drain FSM.
module inst_issue_arbiter #(
   parameter int INST_W     = 8,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_BURST  = 4,
   parameter int DROP_NOP   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INST_W-1:0] req0_inst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [INST_W-1:0] req1_inst,
   input  logic              req1_valid,
   output logic              req1_ready,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic              grant_id,
   input  logic              drain,
   output logic              drain_done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]        state;
   logic [INST_W-1:0] mem [2][FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr [2];
   logic [PW-1:0]     rd_ptr [2];
   logic [CW-1:0]     cnt [2];
   logic [INST_W-1:0] in_data [2];
   logic [1:0]        in_valid;
   logic [1:0]        full;
   logic [1:0]        empty;
   logic [1:0]        rdy;
   logic [1:0]        push;
   logic [1:0]        pop;
   logic              owner;
   logic [BW-1:0]     burst_cnt;
   logic              slot_free;
   logic              pop_any;
   logic              sel;
   logic [INST_W-1:0] head;
   logic              is_nop;
   logic              issue;

   assign in_data[0] = req0_inst;
   assign in_data[1] = req1_inst;
   assign in_valid   = {req1_valid, req0_valid};
   assign req0_ready = rdy[0];
   assign req1_ready = rdy[1];
   assign drain_done = (state == ST_DONE);

   // Ready never looks at the pop side, so a full FIFO refuses even while it is being drained.
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         full[g]  = (cnt[g] == FULL_CNT);
         empty[g] = (cnt[g] == '0);
         rdy[g]   = !full[g] && (state == ST_RUN) && !rst;
         push[g]  = in_valid[g] && rdy[g];
      end
   end

   assign slot_free = !inst_valid || inst_ready;
   assign pop_any   = slot_free && (!empty[0] || !empty[1]) && (state != ST_DONE);

   always_comb begin
      sel = owner;
      if (empty[0])
         sel = 1'b1;
      else if (empty[1])
         sel = 1'b0;
      else if (burst_cnt >= BURST_MAX)
         sel = !owner;
   end

   assign pop[0] = pop_any && !sel;
   assign pop[1] = pop_any && sel;
   assign head   = mem[sel][rd_ptr[sel]];
   assign is_nop = (DROP_NOP != 0) && (head[INST_W-1 -: 2] == 2'b00);
   assign issue  = pop_any && !is_nop;

   always_ff @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (push[g])
            mem[g][wr_ptr[g]] <= in_data[g];
      end
   end

   // Pointers are log2(depth) wide, so they wrap on their own.
   always_ff @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            wr_ptr[g] <= '0;
            rd_ptr[g] <= '0;
            cnt[g]    <= '0;
         end else begin
            if (push[g])
               wr_ptr[g] <= wr_ptr[g] + PW'(1);
            if (pop[g])
               rd_ptr[g] <= rd_ptr[g] + PW'(1);
            case ({push[g], pop[g]})
               2'b10:   cnt[g] <= cnt[g] + CW'(1);
               2'b01:   cnt[g] <= cnt[g] - CW'(1);
               default: cnt[g] <= cnt[g];
            endcase
         end
      end
   end

   // Dropped NOPs still count toward the burst of their owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= 1'b0;
         burst_cnt <= '0;
      end else if (pop_any) begin
         if (sel != owner) begin
            owner     <= sel;
            burst_cnt <= BW'(1);
         end else if (burst_cnt < BURST_MAX) begin
            burst_cnt <= burst_cnt + BW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst       <= '0;
         grant_id   <= 1'b0;
         inst_valid <= 1'b0;
      end else if (slot_free) begin
         if (issue) begin
            inst       <= head;
            grant_id   <= sel;
            inst_valid <= 1'b1;
         end else begin
            inst_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:
               if (drain)
                  state <= ST_DRAIN;
            ST_DRAIN:
               if (!drain)
                  state <= ST_RUN;
               else if (empty[0] && empty[1] && slot_free && !pop_any)
                  state <= ST_DONE;
            ST_DONE:
               if (!drain)
                  state <= ST_RUN;
            default:
               state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_issue_arbiter.sv
// Bench for inst_issue_arbiter: directed streams into both requesters, expected issues queued
// up front and checked by a monitor; a second instance runs with NOP dropping enabled.
module tb_inst_issue_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req0_inst, req1_inst;
   logic       req0_valid, req1_valid;
   logic       inst_ready, drain;

   logic       req0_ready, req1_ready, inst_valid, grant_id, drain_done;
   logic [7:0] inst;
   logic       n_req0_ready, n_req1_ready, n_inst_valid, n_grant_id, n_drain_done;
   logic [7:0] n_inst;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp_n_q[$];
   logic [7:0] src0 [16];
   logic [7:0] src1 [16];

   always #5 clk = ~clk;

   inst_issue_arbiter #(.INST_W(8), .FIFO_DEPTH(2), .MAX_BURST(4), .DROP_NOP(0)) u_dut (
      .clk(clk), .rst(rst),
      .req0_inst(req0_inst), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_inst(req1_inst), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .grant_id(grant_id), .drain(drain), .drain_done(drain_done)
   );

   inst_issue_arbiter #(.INST_W(8), .FIFO_DEPTH(2), .MAX_BURST(4), .DROP_NOP(1)) u_dut_nop (
      .clk(clk), .rst(rst),
      .req0_inst(req0_inst), .req0_valid(req0_valid), .req0_ready(n_req0_ready),
      .req1_inst(req1_inst), .req1_valid(req1_valid), .req1_ready(n_req1_ready),
      .inst(n_inst), .inst_valid(n_inst_valid), .inst_ready(inst_ready),
      .grant_id(n_grant_id), .drain(drain), .drain_done(n_drain_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic g, input logic [7:0] d);
      exp_q.push_back({g, d});
      exp_n_q.push_back({g, d});
   endtask

   // Inputs change on negedge; everything is sampled 1 time unit later.
   always @(negedge clk) begin
      logic [8:0] e;
      #1;
      if (!rst && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected issue", {23'd0, grant_id, inst}, 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check("issue", {23'd0, grant_id, inst}, {23'd0, e});
         end
      end
      if (!rst && n_inst_valid && inst_ready) begin
         if (exp_n_q.size() == 0) begin
            check("unexpected issue nop", {23'd0, n_grant_id, n_inst}, 32'hffff_ffff);
         end else begin
            e = exp_n_q.pop_front();
            check("issue nop", {23'd0, n_grant_id, n_inst}, {23'd0, e});
         end
      end
   end

   task automatic stream(input int port, input int n);
      logic hs;
      int   guard;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (port == 0) begin
            req0_valid = 1'b1;
            req0_inst  = src0[i];
         end else begin
            req1_valid = 1'b1;
            req1_inst  = src1[i];
         end
         #1 hs = (port == 0) ? req0_ready : req1_ready;
         guard = 0;
         while (!hs && guard < 50) begin
            @(negedge clk);
            #1 hs = (port == 0) ? req0_ready : req1_ready;
            guard++;
         end
         check("req accept", {31'd0, hs}, 32'd1);
         @(posedge clk);
      end
      @(negedge clk);
      if (port == 0) req0_valid = 1'b0;
      else           req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || exp_n_q.size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("expected queue empty", exp_q.size() + exp_n_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ready0 in rst", {31'd0, req0_ready}, 0);
      check("ready1 in rst", {31'd0, req1_ready}, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req0_inst = '0; req1_inst = '0; req0_valid = 1'b0; req1_valid = 1'b0;
      inst_ready = 1'b0; drain = 1'b0;
      for (int i = 0; i < 16; i++) begin
         src0[i] = 8'h40 | 8'(i);
         src1[i] = 8'h80 | 8'(i);
      end
      repeat (2) @(negedge clk);
      #1;
      check("ready0 during reset", {31'd0, req0_ready}, 0);
      check("ready1 during reset", {31'd0, req1_ready}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset inst_valid", {31'd0, inst_valid}, 0);
      check("reset inst", {24'd0, inst}, 0);
      check("reset grant_id", {31'd0, grant_id}, 0);
      check("reset drain_done", {31'd0, drain_done}, 0);
      check("reset ready0", {31'd0, req0_ready}, 1);
      check("reset ready1", {31'd0, req1_ready}, 1);

      // T1: single instruction latency
      @(negedge clk);
      inst_ready = 1'b1;
      req0_valid = 1'b1;
      req0_inst  = 8'h41;
      push_exp(1'b0, 8'h41);
      @(negedge clk);
      req0_valid = 1'b0;
      #1 check("t1 valid after e1", {31'd0, inst_valid}, 0);
      @(negedge clk);
      #1;
      check("t1 valid after e2", {31'd0, inst_valid}, 1);
      check("t1 inst after e2", {24'd0, inst}, 32'h41);
      check("t1 grant after e2", {31'd0, grant_id}, 0);
      @(negedge clk);
      #1 check("t1 valid after e3", {31'd0, inst_valid}, 0);
      wait_idle();

      // T2: both streaming -> groups of four alternate, starting with req0
      do_reset();
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < 4; k++)
            push_exp(1'(g % 2), (g % 2 == 0) ? src0[(g / 2) * 4 + k] : src1[(g / 2) * 4 + k]);
      fork
         stream(0, 8);
         stream(1, 8);
      join
      wait_idle();

      // T3: backpressure with both FIFOs full plus a loaded slot
      do_reset();
      @(negedge clk);
      inst_ready = 1'b0;
      push_exp(1'b0, src0[0]); push_exp(1'b0, src0[1]); push_exp(1'b0, src0[2]);
      push_exp(1'b1, src1[0]); push_exp(1'b1, src1[1]);
      fork
         stream(0, 3);
         stream(1, 2);
      join
      for (int c = 0; c < 5; c++) begin
         #1;
         check("t3 hold valid", {31'd0, inst_valid}, 1);
         check("t3 hold inst", {24'd0, inst}, {24'd0, src0[0]});
         check("t3 ready0 full", {31'd0, req0_ready}, 0);
         check("t3 ready1 full", {31'd0, req1_ready}, 0);
         @(negedge clk);
      end
      inst_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1 check("t3 back-to-back valid", {31'd0, inst_valid}, 1);
         @(negedge clk);
      end
      #1 check("t3 valid after burst", {31'd0, inst_valid}, 0);
      wait_idle();

      // T4: drain with three pending entries
      do_reset();
      @(negedge clk);
      inst_ready = 1'b0;
      push_exp(1'b0, src0[0]); push_exp(1'b0, src0[1]); push_exp(1'b1, src1[0]);
      fork
         stream(0, 2);
         stream(1, 1);
      join
      drain = 1'b1;
      @(negedge clk);
      inst_ready = 1'b1;
      #1;
      check("t4 ready0 in drain", {31'd0, req0_ready}, 0);
      check("t4 ready1 in drain", {31'd0, req1_ready}, 0);
      check("t4 done early", {31'd0, drain_done}, 0);
      @(negedge clk);
      #1 check("t4 done after hs1", {31'd0, drain_done}, 0);
      @(negedge clk);
      #1 check("t4 done after hs2", {31'd0, drain_done}, 0);
      @(negedge clk);
      #1;
      check("t4 done after last hs", {31'd0, drain_done}, 1);
      check("t4 valid in done", {31'd0, inst_valid}, 0);
      check("t4 nop done", {31'd0, n_drain_done}, 1);
      @(negedge clk);
      drain = 1'b0;
      @(negedge clk);
      #1;
      check("t4 ready0 resumes", {31'd0, req0_ready}, 1);
      check("t4 done cleared", {31'd0, drain_done}, 0);
      wait_idle();

      // T5: NOPs are popped but only dropped in the DROP_NOP instance
      do_reset();
      src1[0] = 8'h00; src1[1] = 8'h92; src1[2] = 8'h00;
      exp_q.push_back({1'b1, 8'h00});
      exp_q.push_back({1'b1, 8'h92});
      exp_q.push_back({1'b1, 8'h00});
      exp_n_q.push_back({1'b1, 8'h92});
      fork
         stream(1, 3);
      join
      wait_idle();
      // req1 owns with burst 3: one more req1 pop, then req0 takes over
      @(negedge clk);
      inst_ready = 1'b0;
      src0[0] = 8'h51; src0[1] = 8'h52; src1[0] = 8'hA1; src1[1] = 8'hA2;
      push_exp(1'b1, 8'hA1); push_exp(1'b0, 8'h51); push_exp(1'b0, 8'h52); push_exp(1'b1, 8'hA2);
      fork
         stream(0, 2);
         stream(1, 2);
      join
      inst_ready = 1'b1;
      wait_idle();

      // T6: reset with full FIFOs and a loaded slot discards everything
      for (int i = 0; i < 16; i++) begin
         src0[i] = 8'h40 | 8'(i);
         src1[i] = 8'h80 | 8'(i);
      end
      do_reset();
      @(negedge clk);
      inst_ready = 1'b0;
      fork
         stream(0, 3);
         stream(1, 2);
      join
      #1 check("t6 valid before rst", {31'd0, inst_valid}, 1);
      @(negedge clk);
      rst = 1'b1;
      #1 check("t6 ready0 in rst", {31'd0, req0_ready}, 0);
      @(negedge clk);
      rst = 1'b0;
      inst_ready = 1'b1;
      #1;
      check("t6 valid after rst", {31'd0, inst_valid}, 0);
      check("t6 nop valid after rst", {31'd0, n_inst_valid}, 0);
      check("t6 ready0 after rst", {31'd0, req0_ready}, 1);
      check("t6 ready1 after rst", {31'd0, req1_ready}, 1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1 check("t6 no stale issue", {31'd0, inst_valid | n_inst_valid}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
